// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result-capture slice: opcode encodings,
// capture-entry layout and the invalid-operation classifier.
// Ports: none (package).
package alsu_pkg;

   // ALSU opcode encodings
   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_XOR   = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_SHIFT = 3'd4;
   localparam logic [2:0] OP_ROT   = 3'd5;
   localparam logic [2:0] OP_INV6  = 3'd6;
   localparam logic [2:0] OP_INV7  = 3'd7;

   // Captured entry layout: [7] invalid, [6] leds non-zero, [5:0] out
   localparam int ENTRY_W     = 8;
   localparam int ENT_INV     = 7;
   localparam int ENT_LNZ     = 6;
   localparam int ENT_OUT_MSB = 5;

   // An operation is invalid when it uses a reserved opcode, or when a
   // reduction is requested on an opcode that has no reduction form
   // (ADD..ROT). Any bypass request makes the result a plain pass-through,
   // which is always valid.
   function automatic logic is_invalid(input logic [2:0] opcode,
                                       input logic       red,
                                       input logic       bypass);
      logic reserved;
      logic bad_red;
      reserved = (opcode >= OP_INV6);
      bad_red  = (opcode >= OP_ADD) && (opcode <= OP_ROT) && red;
      return !bypass && (reserved || bad_red);
   endfunction

   // Pack one capture entry.
   function automatic logic [ENTRY_W-1:0] make_entry(input logic       inv,
                                                     input logic       lnz,
                                                     input logic [5:0] out);
      logic [ENTRY_W-1:0] e;
      e                  = '0;
      e[ENT_INV]         = inv;
      e[ENT_LNZ]         = lnz;
      e[ENT_OUT_MSB:0]   = out;
      return e;
   endfunction

endpackage

// File: rtl/alsu_res_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a push is visible at the head (empty=0) one cycle later.
// Backpressure: push while full is refused unless a pop happens the same cycle; pop while empty is ignored.
// Ports: clk/rst (async active-high); push/push_data write side;
//        pop/pop_data read side (pop_data is the head, zero when empty);
//        full, empty, fill (occupancy 0..DEPTH).
module alsu_res_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW     = $clog2(DEPTH);
   localparam int FILL_W = AW + 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [FILL_W-1:0] count;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count == FILL_W'(DEPTH));
   assign empty = (count == '0);
   assign fill  = count;

   assign rd_en = pop && !empty;
   // When full, the slot being popped this cycle is the one written, so a
   // simultaneous pop makes room for the push.
   assign wr_en = push && (!full || rd_en);

   // Head is gated to zero when empty so the output is defined out of reset
   // without resetting the storage array.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + FILL_W'(1);
            2'b01:   count <= count - FILL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alsu_result_capture.sv
// Captures ALSU results on the cycle they become valid, classifies them and buffers them for a reader.
// Latency: result valid at issue+LATENCY, entry at rd_valid/rd_data one cycle later (issue+LATENCY+1).
// Backpressure: rd_ready pops the head; a capture arriving while full with no pop is dropped and sets sticky overflow.
// Ports: clk, rst (async active-high);
//        issue_valid/issue_opcode/issue_red/issue_bypass: operation presented to the ALSU;
//        alsu_out/alsu_leds: ALSU result bus, sampled only on the matching cycle;
//        rd_ready/rd_valid/rd_data/fill: FWFT read port and occupancy;
//        overflow, clr_stats, result_count, invalid_count: statistics.
module alsu_result_capture
   import alsu_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   input  logic [2:0]                issue_opcode,
   input  logic                      issue_red,
   input  logic                      issue_bypass,
   input  logic [5:0]                alsu_out,
   input  logic [15:0]               alsu_leds,
   input  logic                      rd_ready,
   output logic                      rd_valid,
   output logic [ENTRY_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]    fill,
   output logic                      overflow,
   input  logic                      clr_stats,
   output logic [CNT_W-1:0]          result_count,
   output logic [CNT_W-1:0]          invalid_count
);

   logic               issue_inv;
   logic [LATENCY-1:0] dl_vld;
   logic [LATENCY-1:0] dl_inv;
   logic               cap_vld;
   logic               cap_inv;
   logic [ENTRY_W-1:0] cap_entry;
   logic               fifo_full;
   logic               fifo_empty;
   logic               drop;

   // Classification is done at issue time, while the opcode and modifiers
   // are still on the ALSU inputs; only the one-bit verdict travels down
   // the delay line.
   assign issue_inv = is_invalid(issue_opcode, issue_red, issue_bypass);

   // Tag delay line, matched to the ALSU input-to-output latency. It shifts
   // every cycle so back-to-back issues each get their own slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_vld <= '0;
         dl_inv <= '0;
      end else begin
         dl_vld[0] <= issue_valid;
         dl_inv[0] <= issue_valid && issue_inv;
         for (int i = 1; i < LATENCY; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_inv[i] <= dl_inv[i-1];
         end
      end
   end

   // The last stage lines up with the cycle in which alsu_out/alsu_leds
   // carry the result of that operation.
   assign cap_vld   = dl_vld[LATENCY-1];
   assign cap_inv   = dl_inv[LATENCY-1];
   assign cap_entry = make_entry(cap_inv, |alsu_leds, alsu_out);

   // The ALSU bus only reaches the FIFO storage, so rd_* never depend
   // combinationally on alsu_*.
   alsu_res_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cap_vld),
      .push_data (cap_entry),
      .pop       (rd_ready),
      .pop_data  (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .fill      (fill)
   );

   assign rd_valid = !fifo_empty;

   // A pop while full frees the slot the push needs, so only an unpopped
   // full FIFO loses the capture.
   assign drop = cap_vld && fifo_full && !rd_ready;

   // Statistics. Clear wins over any same-cycle increment or overflow event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow      <= 1'b0;
         result_count  <= '0;
         invalid_count <= '0;
      end else if (clr_stats) begin
         overflow      <= 1'b0;
         result_count  <= '0;
         invalid_count <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end
         // Dropped entries still count as results.
         if (cap_vld && (result_count != '1)) begin
            result_count <= result_count + CNT_W'(1);
         end
         if (cap_vld && cap_inv && (invalid_count != '1)) begin
            invalid_count <= invalid_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alsu_result_capture.sv
// Testbench for alsu_result_capture: directed vectors, expected entries queued at issue and checked by a monitor on each read handshake.
module tb_alsu_result_capture;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [2:0]  issue_opcode;
   logic        issue_red;
   logic        issue_bypass;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic        rd_ready;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic [3:0]  fill;
   logic        overflow;
   logic        clr_stats;
   logic [15:0] result_count;
   logic [15:0] invalid_count;

   int checks = 0;
   int errors = 0;
   bit sb_en  = 1'b1;

   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;

   // Bench-side stand-in for the ALSU's 2-cycle pipeline.
   logic [5:0]  d_out  [2];
   logic [15:0] d_leds [2];

   alsu_result_capture #(
      .LATENCY (2),
      .DEPTH   (8),
      .CNT_W   (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_opcode  (issue_opcode),
      .issue_red     (issue_red),
      .issue_bypass  (issue_bypass),
      .alsu_out      (alsu_out),
      .alsu_leds     (alsu_leds),
      .rd_ready      (rd_ready),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .fill          (fill),
      .overflow      (overflow),
      .clr_stats     (clr_stats),
      .result_count  (result_count),
      .invalid_count (invalid_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus. The result for an op issued now is put on
   // alsu_out two cycles later; non-issue cycles feed random junk so a
   // mis-timed capture shows up as a data error.
   task automatic tick(input logic iv, input logic [2:0] op, input logic red,
                       input logic byp, input logic [5:0] out, input logic [15:0] leds,
                       input logic exp_push, input logic [7:0] exp_ent);
      issue_valid  = iv;
      issue_opcode = op;
      issue_red    = red;
      issue_bypass = byp;
      alsu_out     = d_out[1];
      alsu_leds    = d_leds[1];
      d_out[1]     = d_out[0];
      d_leds[1]    = d_leds[0];
      d_out[0]     = iv ? out  : 6'($urandom);
      d_leds[0]    = iv ? leds : 16'($urandom);
      if (iv && exp_push) exp_q.push_back(exp_ent);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 3'd0, 1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 8'h00);
   endtask

   // Scoreboard monitor: every accepted head entry must match the oldest
   // expected entry.
   always @(negedge clk) begin
      if (!rst && sb_en && rd_valid && rd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h", rd_data, mon_exp);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; issue_valid = 1'b0; issue_opcode = 3'd0; issue_red = 1'b0;
      issue_bypass = 1'b0; alsu_out = 6'd0; alsu_leds = 16'd0;
      rd_ready = 1'b0; clr_stats = 1'b0;
      d_out[0] = 6'd0; d_out[1] = 6'd0; d_leds[0] = 16'd0; d_leds[1] = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_fill", 32'(fill), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_result_count", 32'(result_count), 0);
      chk("rst_invalid_count", 32'(invalid_count), 0);
      rst = 1'b0;

      // Single op: ADD, out=9 -> entry 8'h09 at issue+3
      tick(1'b1, 3'd2, 1'b0, 1'b0, 6'd9, 16'h0000, 1'b1, 8'h09);
      idle();
      chk("single_not_early", 32'(rd_valid), 0);
      idle();
      chk("single_rd_valid", 32'(rd_valid), 1);
      chk("single_rd_data", 32'(rd_data), 32'h09);
      chk("single_result_count", 32'(result_count), 1);
      chk("single_invalid_count", 32'(invalid_count), 0);
      rd_ready = 1'b1;
      idle();
      rd_ready = 1'b0;
      chk("single_drained", 32'(fill), 0);

      // Invalid classes: reserved op, reduction on MUL, bypassed reserved op
      tick(1'b1, 3'd6, 1'b0, 1'b0, 6'h3F, 16'h0000, 1'b1, 8'hBF);
      tick(1'b1, 3'd3, 1'b1, 1'b0, 6'h05, 16'h0100, 1'b1, 8'hC5);
      tick(1'b1, 3'd7, 1'b0, 1'b1, 6'h02, 16'h0001, 1'b1, 8'h42);
      idle();
      idle();
      chk("inv_fill", 32'(fill), 3);
      chk("inv_head", 32'(rd_data), 32'hBF);
      chk("inv_result_count", 32'(result_count), 4);
      chk("inv_invalid_count", 32'(invalid_count), 2);
      rd_ready = 1'b1;
      idle();
      rd_ready = 1'b0;
      chk("inv_fill_after_pop", 32'(fill), 2);

      // Reset mid-flight: issue, then async reset pulse the next cycle
      tick(1'b1, 3'd0, 1'b0, 1'b0, 6'h07, 16'h0000, 1'b0, 8'h00);
      rst = 1'b1;
      exp_q.delete();
      #2;
      rst = 1'b0;
      rd_ready = 1'b1;
      repeat (4) idle();
      rd_ready = 1'b0;
      chk("rstmid_rd_valid", 32'(rd_valid), 0);
      chk("rstmid_fill", 32'(fill), 0);
      chk("rstmid_result_count", 32'(result_count), 0);
      chk("rstmid_invalid_count", 32'(invalid_count), 0);

      // Back-to-back: 8 issues fill the FIFO, the 9th is dropped
      for (int i = 1; i <= 9; i++) begin
         tick(1'b1, 3'd1, 1'b0, 1'b0, 6'(i), 16'h0000, (i <= 8), 8'(i));
      end
      idle();
      chk("b2b_fill", 32'(fill), 8);
      chk("b2b_no_overflow_yet", 32'(overflow), 0);
      idle();
      chk("b2b_overflow", 32'(overflow), 1);
      chk("b2b_result_count", 32'(result_count), 9);
      chk("b2b_head", 32'(rd_data), 32'h01);
      chk("b2b_fill_after_drop", 32'(fill), 8);

      // Clear stats leaves FIFO contents alone
      clr_stats = 1'b1;
      idle();
      clr_stats = 1'b0;
      chk("clr_overflow", 32'(overflow), 0);
      chk("clr_result_count", 32'(result_count), 0);
      chk("clr_fill", 32'(fill), 8);

      // Full with simultaneous pop on the capture cycle
      tick(1'b1, 3'd1, 1'b0, 1'b0, 6'h0A, 16'h0000, 1'b1, 8'h0A);
      idle();
      rd_ready = 1'b1;
      idle();
      rd_ready = 1'b0;
      chk("fullpop_fill", 32'(fill), 8);
      chk("fullpop_overflow", 32'(overflow), 0);
      chk("fullpop_head", 32'(rd_data), 32'h02);

      // Drain everything through the scoreboard
      rd_ready = 1'b1;
      repeat (10) idle();
      chk("drain_fill", 32'(fill), 0);
      chk("drain_queue_empty", 32'(exp_q.size()), 0);

      // Saturation: 65534 results, then 3 invalid ones
      sb_en = 1'b0;
      clr_stats = 1'b1;
      idle();
      clr_stats = 1'b0;
      for (int i = 0; i < 65534; i++) begin
         tick(1'b1, 3'd0, 1'b0, 1'b0, 6'(i), 16'h0000, 1'b0, 8'h00);
      end
      idle();
      idle();
      chk("sat_pre_result_count", 32'(result_count), 32'hFFFE);
      chk("sat_pre_invalid_count", 32'(invalid_count), 0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 3'd7, 1'b0, 1'b0, 6'h11, 16'h0000, 1'b0, 8'h00);
      end
      idle();
      idle();
      chk("sat_result_count", 32'(result_count), 32'hFFFF);
      chk("sat_invalid_count", 32'(invalid_count), 3);

      // Clear coincident with a capture: clear wins
      tick(1'b1, 3'd6, 1'b0, 1'b0, 6'h01, 16'h0000, 1'b0, 8'h00);
      idle();
      clr_stats = 1'b1;
      idle();
      clr_stats = 1'b0;
      chk("clrcap_result_count", 32'(result_count), 0);
      chk("clrcap_invalid_count", 32'(invalid_count), 0);
      idle();
      chk("clrcap_result_hold", 32'(result_count), 0);
      chk("clrcap_overflow", 32'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
